spi_slave_ctrl: RTL

- Chip-side SPI target (responder) in the `top` SPI path, facing the FPGA `host_spi` initiator.
- Oversamples `spi_clk`/`spi_csn`/`spi_mosi` in the chip clock domain and decodes the 41-bit frame `{cmd[1:0], addr[21:0], NA, data[15:0]}`.
- Issues single-cycle write/read requests to the register/SRAM address decoder and serialises read data back on `spi_miso`.
- Requirement: chip clock ≥10× `spi_clk`.

---
 rtl/spi_slave_ctrl_pkg.sv | 20 ++
 rtl/spi_slave_ctrl_if.sv | 27 ++
 rtl/spi_in_sync.sv | 46 ++++
 rtl/spi_slave_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_ctrl_pkg.sv
// Shared constants, frame geometry and FSM state type for the chip-side SPI target.
package spi_slave_ctrl_pkg;
   localparam int INTERFACE_ADDR_WIDTH = 22;
   localparam int INTERFACE_DATA_WIDTH = 16;

   localparam logic [1:0] SPI_CMD_RD = 2'b01;
   localparam logic [1:0] SPI_CMD_WR = 2'b10;

   localparam int SPI_HDR_BITS   = 2 + INTERFACE_ADDR_WIDTH;
   localparam int SPI_FRAME_BITS = SPI_HDR_BITS + 1 + INTERFACE_DATA_WIDTH;
   localparam int SPI_CNT_W      = 6;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_TURN,
      ST_DATA,
      ST_SKIP
   } spi_state_e;
endpackage

// File: rtl/spi_slave_ctrl_if.sv
// SPI pins plus the register/SRAM request bus of the SPI target.
interface spi_slave_ctrl_if #(
   parameter int ADDR_W = spi_slave_ctrl_pkg::INTERFACE_ADDR_WIDTH,
   parameter int DATA_W = spi_slave_ctrl_pkg::INTERFACE_DATA_WIDTH
);
   logic              spi_clk;
   logic              spi_csn;
   logic              spi_mosi;
   logic              spi_miso;
   logic [ADDR_W-1:0] spi_addr;
   logic              spi_wen;
   logic [DATA_W-1:0] spi_wdata;
   logic              spi_ren;
   logic [DATA_W-1:0] spi_rdata;
   logic              spi_rvalid;
   logic              frame_err;

   modport slave (
      input  spi_clk, spi_csn, spi_mosi, spi_rdata, spi_rvalid,
      output spi_miso, spi_addr, spi_wen, spi_wdata, spi_ren, frame_err
   );

   modport master (
      output spi_clk, spi_csn, spi_mosi, spi_rdata, spi_rvalid,
      input  spi_miso, spi_addr, spi_wen, spi_wdata, spi_ren, frame_err
   );
endinterface

// File: rtl/spi_in_sync.sv
// Synchronises SCK/CSN/MOSI into the chip clock and detects SCK and CSN edges.
module spi_in_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sck_i,
   input  logic csn_i,
   input  logic mosi_i,
   output logic sck_rise_o,
   output logic sck_fall_o,
   output logic csn_fall_o,
   output logic csn_rise_o,
   output logic mosi_o
);
   // Bit order per stage: {sck, csn, mosi}. CSN resets low so a reset in
   // the middle of a frame cannot fabricate a CSN fall afterwards.
   logic [SYNC_STAGES-1:0][2:0] sync_q;
   logic                        sck_hist_q;
   logic                        csn_hist_q;
   logic                        sck_s;
   logic                        csn_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q     <= '0;
         sck_hist_q <= 1'b0;
         csn_hist_q <= 1'b0;
      end else begin
         sync_q[0] <= {sck_i, csn_i, mosi_i};
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         sck_hist_q <= sync_q[SYNC_STAGES-1][2];
         csn_hist_q <= sync_q[SYNC_STAGES-1][1];
      end
   end

   assign sck_s      = sync_q[SYNC_STAGES-1][2];
   assign csn_s      = sync_q[SYNC_STAGES-1][1];
   assign mosi_o     = sync_q[SYNC_STAGES-1][0];
   assign sck_rise_o = sck_s & ~sck_hist_q;
   assign sck_fall_o = ~sck_s & sck_hist_q;
   assign csn_fall_o = ~csn_s & csn_hist_q;
   assign csn_rise_o = csn_s & ~csn_hist_q;
endmodule

// File: rtl/spi_slave_ctrl.sv
// Chip-side SPI mode-0 target: decodes {cmd, addr, NA, data} frames into
// single-cycle register/SRAM requests and returns read data on MISO.
module spi_slave_ctrl
   import spi_slave_ctrl_pkg::*;
#(
   parameter int ADDR_W      = INTERFACE_ADDR_WIDTH,
   parameter int DATA_W      = INTERFACE_DATA_WIDTH,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   spi_slave_ctrl_if.slave  bus
);
   localparam int HdrBits   = ADDR_W + 2;
   localparam int FrameBits = HdrBits + 1 + DATA_W;

   logic sck_rise, sck_fall, csn_fall, csn_rise, mosi_s;

   spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk        (clk),
      .rst_n      (rst_n),
      .sck_i      (bus.spi_clk),
      .csn_i      (bus.spi_csn),
      .mosi_i     (bus.spi_mosi),
      .sck_rise_o (sck_rise),
      .sck_fall_o (sck_fall),
      .csn_fall_o (csn_fall),
      .csn_rise_o (csn_rise),
      .mosi_o     (mosi_s)
   );

   spi_state_e           state_q, state_d;
   logic [SPI_CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic [HdrBits-2:0]   hdr_q, hdr_d;
   logic [HdrBits-1:0]   hdr_shift;
   logic [DATA_W-2:0]    rx_q, rx_d;
   logic [DATA_W-1:0]    rx_shift;
   logic [DATA_W-1:0]    tx_q, tx_d;
   logic [DATA_W-1:0]    wdata_q, wdata_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic                 rd_q, rd_d, got_q, got_d, late_q, late_d;
   logic                 miso_q, miso_d, wen_q, wen_d, ren_q, ren_d, err_q, err_d;

   assign hdr_shift = {hdr_q, mosi_s};
   assign rx_shift  = {rx_q, mosi_s};
   assign cnt_inc   = (sck_rise && cnt_q < SPI_CNT_W'(FrameBits)) ? cnt_q + 1'b1 : cnt_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hdr_d   = hdr_q;
      rx_d    = rx_q;
      tx_d    = tx_q;
      wdata_d = wdata_q;
      addr_d  = addr_q;
      rd_d    = rd_q;
      got_d   = got_q;
      late_d  = late_q;
      miso_d  = (state_q == ST_DATA && rd_q) ? miso_q : 1'b0;
      wen_d   = 1'b0;
      ren_d   = 1'b0;
      err_d   = 1'b0;

      // Read data is only accepted inside the read window, once per frame.
      if (rd_q && (state_q == ST_TURN || state_q == ST_DATA) &&
          bus.spi_rvalid && !got_q && !late_q) begin
         tx_d  = bus.spi_rdata;
         got_d = 1'b1;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (csn_fall) begin
               state_d = ST_HDR;
               cnt_d   = '0;
               hdr_d   = '0;
               rx_d    = '0;
               tx_d    = '0;
               rd_d    = 1'b0;
               got_d   = 1'b0;
               late_d  = 1'b0;
            end
         end
         ST_HDR: begin
            cnt_d = cnt_inc;
            if (sck_rise) begin
               hdr_d = hdr_shift[HdrBits-2:0];
               if (cnt_inc == SPI_CNT_W'(HdrBits)) begin
                  if (hdr_shift[HdrBits-1 -: 2] == SPI_CMD_RD) begin
                     addr_d  = hdr_shift[ADDR_W-1:0];
                     ren_d   = 1'b1;
                     rd_d    = 1'b1;
                     state_d = ST_TURN;
                  end else if (hdr_shift[HdrBits-1 -: 2] == SPI_CMD_WR) begin
                     addr_d  = hdr_shift[ADDR_W-1:0];
                     state_d = ST_TURN;
                  end else begin
                     err_d   = 1'b1;
                     state_d = ST_SKIP;
                  end
               end
            end
         end
         ST_TURN: begin
            cnt_d = cnt_inc;
            if (sck_rise) state_d = ST_DATA;
         end
         ST_DATA: begin
            cnt_d = cnt_inc;
            if (rd_q) begin
               // First fall without data closes the window: report once, send zeros.
               if (sck_fall) begin
                  if (!got_q) begin
                     err_d  = !late_q;
                     late_d = 1'b1;
                     got_d  = 1'b0;
                     tx_d   = '0;
                     miso_d = 1'b0;
                  end else begin
                     miso_d = tx_q[DATA_W-1];
                     tx_d   = tx_q << 1;
                  end
               end
               if (sck_rise && cnt_inc == SPI_CNT_W'(FrameBits)) state_d = ST_SKIP;
            end else if (sck_rise) begin
               rx_d = rx_shift[DATA_W-2:0];
               if (cnt_inc == SPI_CNT_W'(FrameBits)) begin
                  wdata_d = rx_shift;
                  wen_d   = 1'b1;
                  state_d = ST_SKIP;
               end
            end
         end
         ST_SKIP: begin
            cnt_d = cnt_inc;
         end
         default: state_d = ST_IDLE;
      endcase

      if (csn_rise && state_q != ST_IDLE) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         miso_d  = 1'b0;
         wen_d   = 1'b0;
         ren_d   = 1'b0;
         err_d   = (cnt_q < SPI_CNT_W'(FrameBits));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         hdr_q   <= '0;
         rx_q    <= '0;
         tx_q    <= '0;
         wdata_q <= '0;
         addr_q  <= '0;
         rd_q    <= 1'b0;
         got_q   <= 1'b0;
         late_q  <= 1'b0;
         miso_q  <= 1'b0;
         wen_q   <= 1'b0;
         ren_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hdr_q   <= hdr_d;
         rx_q    <= rx_d;
         tx_q    <= tx_d;
         wdata_q <= wdata_d;
         addr_q  <= addr_d;
         rd_q    <= rd_d;
         got_q   <= got_d;
         late_q  <= late_d;
         miso_q  <= miso_d;
         wen_q   <= wen_d;
         ren_q   <= ren_d;
         err_q   <= err_d;
      end
   end

   assign bus.spi_miso  = miso_q;
   assign bus.spi_addr  = addr_q;
   assign bus.spi_wen   = wen_q;
   assign bus.spi_wdata = wdata_q;
   assign bus.spi_ren   = ren_q;
   assign bus.frame_err = err_q;
endmodule
